// File: rtl/decode_pkg.sv
// Shared types for the decode stage: fetch instruction word, decoded uop and the RV32 ALU decoder.
// The SIMULATION macro adds a simid tag that travels from the instruction into the uop.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ALU_R,
    ALU_I,
    ILLEGAL
  } t_uop_class;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } t_alu_op;

  typedef struct packed {
`ifdef SIMULATION
    logic [31:0] simid;
`endif
    logic [31:0] bits;
  } t_rv_instr;

  typedef struct packed {
`ifdef SIMULATION
    logic [31:0] simid;
`endif
    t_uop_class  uop_class;
    t_alu_op     alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } t_uop;

  // Operation selected by funct3 when funct7/imm[11:5] is the base encoding.
  function automatic t_alu_op base_op(input logic [2:0] funct3);
    case (funct3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic t_uop decode_rv32(input t_rv_instr instr);
    t_uop        u;
    logic [31:0] w;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;

    // NOTE: every field gets a default before the case so the combinational caller never infers a latch.
    u      = '0;
    legal  = 1'b0;
    w      = instr.bits;
    funct7 = w[31:25];
    funct3 = w[14:12];
    u.rd   = w[11:7];
    u.rs1  = w[19:15];
    u.rs2  = w[24:20];

    case (w[6:0])
      OPC_OP: begin
        u.uop_class = ALU_R;
        u.uses_rs1  = 1'b1;
        u.uses_rs2  = 1'b1;
        if (funct7 == F7_BASE) begin
          legal    = 1'b1;
          u.alu_op = base_op(funct3);
        end else if (funct7 == F7_ALT) begin
          legal    = (funct3 == F3_ADD) || (funct3 == F3_SR);
          u.alu_op = (funct3 == F3_ADD) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        u.uop_class = ALU_I;
        u.uses_rs1  = 1'b1;
        u.alu_op    = base_op(funct3);
        u.imm       = {{20{w[31]}}, w[31:20]};
        legal       = 1'b1;
        // Shift-immediates carry shamt in imm[4:0] and the shift kind in imm[11:5].
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          u.imm = {27'd0, w[24:20]};
          if (funct3 == F3_SR && funct7 == F7_ALT) u.alu_op = ALU_SRA;
          else legal = (funct7 == F7_BASE);
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      u.uop_class = ILLEGAL;
      u.alu_op    = ALU_ADD;
      u.imm       = '0;
      u.uses_rs1  = 1'b0;
      u.uses_rs2  = 1'b0;
      u.illegal   = 1'b1;
    end else begin
      u.writes_rd = (u.rd != 5'd0);
    end
`ifdef SIMULATION
    u.simid = instr.simid;
`endif
    return u;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch->decode->rename handshake bundle. slave is the decode view, master the surrounding pipeline.
interface decode_if;
  import decode_pkg::*;

  logic      fe_valid_de0;
  t_rv_instr instr_de0;
  logic      stall;
  logic      de_valid_rn0;
  t_uop      uop_rn0;
  logic      rn_stall;

  modport slave (
    input  fe_valid_de0, instr_de0, rn_stall,
    output stall, de_valid_rn0, uop_rn0
  );

  modport master (
    output fe_valid_de0, instr_de0, rn_stall,
    input  stall, de_valid_rn0, uop_rn0
  );
endinterface

// File: rtl/decode_iq.sv
// de_iq: in-order circular FIFO with power-of-two depth, wrapping pointers and an occupancy count.
module de_iq #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/decode.sv
// decode: buffers fetched RV32 instructions, decodes the queue head and registers the uop for rename.
// Define DE_PERF_CNT_EN to add the perf_de_* event counters.
module decode
  import decode_pkg::*;
#(
  parameter int IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  decode_if.slave     de
`ifdef DE_PERF_CNT_EN
  ,
  output logic [31:0] perf_de_uops,
  output logic [31:0] perf_de_fe_stall,
  output logic [31:0] perf_de_illegal
`endif
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;

  t_rv_instr     iq_head;
  logic [CW-1:0] iq_count;
  logic          iq_full;
  logic          iq_empty;
  logic          push;
  logic          load;
  t_uop          head_uop;
  t_uop          uop_q;
  logic          valid_q;

  // Backpressure comes only from registered occupancy, never from instr_de0 or rn_stall.
  assign de.stall = iq_full;
  assign push     = de.fe_valid_de0 & ~iq_full;
  assign load     = ~iq_empty & (~valid_q | ~de.rn_stall);

  de_iq #(
    .T     (t_rv_instr),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (de.instr_de0),
    .pop   (load),
    .head  (iq_head),
    .count (iq_count),
    .full  (iq_full),
    .empty (iq_empty)
  );

  // NOTE: combinational logic uses blocking '=', the clocked registers below use '<=' only.
  always_comb begin
    head_uop = decode_rv32(iq_head);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      uop_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      uop_q   <= head_uop;
    end else if (valid_q & ~de.rn_stall) begin
      valid_q <= 1'b0;
    end
  end

  assign de.de_valid_rn0 = valid_q;
  assign de.uop_rn0      = uop_q;

`ifdef DE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_de_uops     <= '0;
      perf_de_fe_stall <= '0;
      perf_de_illegal  <= '0;
    end else begin
      if (valid_q & ~de.rn_stall)                 perf_de_uops     <= perf_de_uops + 32'd1;
      if (de.fe_valid_de0 & iq_full)              perf_de_fe_stall <= perf_de_fe_stall + 32'd1;
      if (valid_q & ~de.rn_stall & uop_q.illegal) perf_de_illegal  <= perf_de_illegal + 32'd1;
    end
  end
`endif

  chk_no_change: assert property (@(posedge clk) disable iff (reset)
    (valid_q && de.rn_stall) |=> ($stable(uop_q) && valid_q));

  chk_count_bound: assert property (@(posedge clk) disable iff (reset)
    (iq_count <= CW'(IQ_DEPTH)) && (iq_full == (iq_count == CW'(IQ_DEPTH))));

endmodule

// File: tb/tb_decode.sv
// Randomized and directed bench for decode against a queue-based reference model.
module tb_decode;
  import decode_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  decode_if dif ();

`ifdef DE_PERF_CNT_EN
  logic [31:0] perf_de_uops;
  logic [31:0] perf_de_fe_stall;
  logic [31:0] perf_de_illegal;
`endif

  decode #(.IQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .de    (dif)
`ifdef DE_PERF_CNT_EN
    ,
    .perf_de_uops     (perf_de_uops),
    .perf_de_fe_stall (perf_de_fe_stall),
    .perf_de_illegal  (perf_de_illegal)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decoder: table lookup on funct3 plus the legality rules, independent of the RTL case tree.
  function automatic t_uop ref_decode(input logic [31:0] w);
    t_uop       u;
    t_alu_op    tbl [8];
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    bit         ok;
    bit         shift;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    u = '0;
    op = w[6:0];
    f7 = w[31:25];
    f3 = w[14:12];
    ok = 0;
    if (op == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      u.uop_class = ALU_R;
      u.uses_rs1 = 1'b1;
      u.uses_rs2 = 1'b1;
      u.alu_op = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : tbl[f3];
    end else if (op == 7'h13) begin
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      ok = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
      u.uop_class = ALU_I;
      u.uses_rs1 = 1'b1;
      u.imm = shift ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      u.alu_op = (shift && f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
    end
    if (!ok) begin
      u = '0;
      u.uop_class = ILLEGAL;
      u.illegal = 1'b1;
    end else begin
      u.writes_rd = (w[11:7] != 5'd0);
    end
    u.rd  = w[11:7];
    u.rs1 = w[19:15];
    u.rs2 = w[24:20];
    return u;
  endfunction

  // Model state: instructions waiting in the queue, and the one held for rename.
  logic [31:0] m_q [$];
  logic        m_valid = 1'b0;
  logic [31:0] m_out   = '0;
  int unsigned n_deliv = 0;
  int unsigned n_ill   = 0;
  int unsigned n_fest  = 0;
  int unsigned dut_deliv = 0;

  // Called at a negedge: check outputs against the model, apply inputs, advance the model one clock.
  task automatic step(input logic fv, input logic [31:0] ins, input logic rs, input logic rst = 1'b0);
    logic      stall_e;
    t_rv_instr ri;
    stall_e = (m_q.size() == DEPTH);
    check("stall", 128'(dif.stall), 128'(stall_e));
    check("valid", 128'(dif.de_valid_rn0), 128'(m_valid));
    if (m_valid) check("uop", 128'(dif.uop_rn0), 128'(ref_decode(m_out)));
`ifdef DE_PERF_CNT_EN
    check("perf_uops", 128'(perf_de_uops), 128'(n_deliv));
    check("perf_fe_stall", 128'(perf_de_fe_stall), 128'(n_fest));
    check("perf_illegal", 128'(perf_de_illegal), 128'(n_ill));
`endif
    if (dif.de_valid_rn0 && !rs && !rst) dut_deliv++;
    ri = '0;
    ri.bits = ins;
    dif.fe_valid_de0 = fv;
    dif.instr_de0 = ri;
    dif.rn_stall = rs;
    reset = rst;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0;
      n_deliv = 0;
      n_ill = 0;
      n_fest = 0;
    end else begin
      if (m_valid && !rs) begin
        n_deliv++;
        if (ref_decode(m_out).illegal) n_ill++;
      end
      if (fv && stall_e) n_fest++;
      if (m_q.size() > 0 && (!m_valid || !rs)) begin
        m_out = m_q.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && !rs) begin
        m_valid = 1'b0;
      end
      if (fv && !stall_e) m_q.push_back(ins);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k < 4) w[6:0] = 7'h33;
    else if (k < 8) w[6:0] = 7'h13;
    if (k < 8 && $urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    logic [31:0] ins;
    logic        fv;
    logic        rs;
    logic        st;
    logic        keep;
    int unsigned acc;
    int unsigned d0;

    reset = 1'b1;
    dif.fe_valid_de0 = 1'b0;
    dif.instr_de0 = '0;
    dif.rn_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(dif.de_valid_rn0), 128'(0));
    check("rst_stall", 128'(dif.stall), 128'(0));
    check("rst_uop", 128'(dif.uop_rn0), 128'(0));

    // Single ADDI x1,x1,0x123: visible two cycles after acceptance, gone the cycle after.
    step(1'b1, 32'h12308093, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("addi_valid", 128'(dif.de_valid_rn0), 128'(1));
    check("addi_class", 128'(dif.uop_rn0.uop_class), 128'(ALU_I));
    check("addi_op", 128'(dif.uop_rn0.alu_op), 128'(ALU_ADD));
    check("addi_rd", 128'(dif.uop_rn0.rd), 128'(1));
    check("addi_rs1", 128'(dif.uop_rn0.rs1), 128'(1));
    check("addi_imm", 128'(dif.uop_rn0.imm), 128'(32'h00000123));
    check("addi_wr", 128'(dif.uop_rn0.writes_rd), 128'(1));
    step(1'b0, 32'h0, 1'b0);
    check("addi_gone", 128'(dif.de_valid_rn0), 128'(0));

    // Back-to-back XOR, SUB, SRAI.
    step(1'b1, 32'h0010C0B3, 1'b0);
    step(1'b1, 32'h40188833, 1'b0);
    check("xor_op", 128'(dif.uop_rn0.alu_op), 128'(ALU_XOR));
    step(1'b1, 32'h40195A13, 1'b0);
    check("sub_op", 128'(dif.uop_rn0.alu_op), 128'(ALU_SUB));
    check("sub_valid", 128'(dif.de_valid_rn0), 128'(1));
    step(1'b0, 32'h0, 1'b0);
    check("srai_op", 128'(dif.uop_rn0.alu_op), 128'(ALU_SRA));
    check("srai_imm", 128'(dif.uop_rn0.imm), 128'(1));
    check("srai_valid", 128'(dif.de_valid_rn0), 128'(1));
    repeat (2) step(1'b0, 32'h0, 1'b0);

    // Rename stalls 10 cycles with fetch always valid: fills DE1 plus the queue, then drains in order.
    acc = 1;
    for (int k = 0; k < 10; k++) begin
      st = (m_q.size() == DEPTH);
      step(1'b1, 32'h00000093 | (acc << 20), 1'b1);
      if (!st) acc++;
    end
    check("bp_stall", 128'(dif.stall), 128'(1));
    check("bp_hold", 128'(dif.uop_rn0), 128'(ref_decode(32'h00100093)));
    d0 = dut_deliv;
    repeat (6) step(1'b0, 32'h0, 1'b0);
    check("bp_drained", 128'(dut_deliv - d0), 128'(5));

    // Illegal encodings are still delivered.
    step(1'b1, 32'h0000007F, 1'b0);
    step(1'b1, 32'h023100B3, 1'b0);
    check("ill_opc_flag", 128'(dif.uop_rn0.illegal), 128'(1));
    check("ill_opc_class", 128'(dif.uop_rn0.uop_class), 128'(ILLEGAL));
    step(1'b0, 32'h0, 1'b0);
    check("ill_f7_flag", 128'(dif.uop_rn0.illegal), 128'(1));
    check("ill_f7_class", 128'(dif.uop_rn0.uop_class), 128'(ILLEGAL));
    repeat (2) step(1'b0, 32'h0, 1'b0);

    // Reset with three queued entries and DE1 valid.
    for (int k = 0; k < 4; k++) step(1'b1, 32'h00000113 | (k << 20), 1'b1);
    check("pre_rst_valid", 128'(dif.de_valid_rn0), 128'(1));
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("mid_rst_valid", 128'(dif.de_valid_rn0), 128'(0));
    check("mid_rst_stall", 128'(dif.stall), 128'(0));
    step(1'b1, 32'h12308093, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("post_rst_valid", 128'(dif.de_valid_rn0), 128'(1));
    check("post_rst_imm", 128'(dif.uop_rn0.imm), 128'(32'h00000123));
    repeat (2) step(1'b0, 32'h0, 1'b0);

    // Random traffic; fetch keeps a stalled instruction stable until it is accepted.
    fv = 1'b0;
    ins = '0;
    keep = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!keep) begin
        fv = ($urandom_range(0, 2) != 0);
        ins = gen_instr();
      end
      rs = ($urandom_range(0, 99) < (((i / 1000) % 2 == 1) ? 70 : 20));
      st = (m_q.size() == DEPTH);
      step(fv, ins, rs);
      keep = fv && st;
    end
    repeat (8) step(1'b0, 32'h0, 1'b0);
    check("final_empty", 128'(dif.de_valid_rn0), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
